// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
// Shared types and constants for the UART transmit arbiter slice.
//   arb_state_e : arbiter FSM encoding (IDLE, LOCKED, SETTLE)
//   UART_DATA_W : byte width handed to uart_tx
//   idx_w()     : index width for an N-entry one-hot vector (minimum 1)
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 8
`endif

package uart_tx_arbiter_pkg;

  localparam int UART_DATA_W = `UART_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    SETTLE = 2'd2
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker: first set bit of i_req scanning upward
// from i_ptr with wrap-around.
//   i_req  : request vector
//   i_ptr  : index with highest priority this round
//   o_pick : one-hot winner (0 when no request)
//   o_idx  : index of the winner
//   o_any  : at least one request present
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_pick,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  int w_j;

  // Scan from lowest priority to highest so the last hit wins.
  always_comb begin
    o_pick = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_j    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = (int'(i_ptr) + k) % N;
      if (i_req[w_j]) begin
        o_pick      = '0;
        o_pick[w_j] = 1'b1;
        o_idx       = PW'(w_j);
        o_any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_tx between NUM_REQ byte-stream requesters. Grants are
// round-robin and held for a whole message (terminated by req_last), with a
// timeout that reclaims the transmitter from a stalled owner.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_req_valid/data/last, o_req_ready : per-requester byte handshake
//   o_uart_tx_data/valid, i_uart_tx_ready : interface to uart_tx
//   o_grant             : one-hot current owner, 0 when idle
//   o_busy              : arbiter not idle
//   o_timeout_evt       : one-cycle pulse on a timeout revoke
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = UART_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]         o_uart_tx_data,
  output logic                          o_uart_tx_valid,
  input  logic                          i_uart_tx_ready,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy,
  output logic                          o_timeout_evt
);

  localparam int PW = idx_w(NUM_REQ);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_e         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [PW-1:0]      r_gidx;
  logic [PW-1:0]      r_rr_ptr;
  logic [TW-1:0]      r_tmo_cnt;
  logic               r_timeout_evt;

  logic [NUM_REQ-1:0] w_pick;
  logic [PW-1:0]      w_pick_idx;
  logic               w_any;
  logic               w_locked;
  logic               w_own_valid;
  logic               w_own_last;
  logic               w_xfer;
  logic               w_tmo_hit;
  logic [PW-1:0]      w_next_ptr;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_rr_pick (
    .i_req  (i_req_valid),
    .i_ptr  (r_rr_ptr),
    .o_pick (w_pick),
    .o_idx  (w_pick_idx),
    .o_any  (w_any)
  );

  assign w_locked    = (r_state == LOCKED);
  assign w_own_valid = |(i_req_valid & r_grant);
  assign w_own_last  = |(i_req_last & r_grant);
  assign w_xfer      = w_locked & w_own_valid & i_uart_tx_ready;
  // Only cycles with the owner silent count toward the timeout, so UART
  // back-pressure can never revoke a grant.
  assign w_tmo_hit   = (TIMEOUT_CYCLES != 0) && w_locked && !w_own_valid &&
                       (r_tmo_cnt == TMO_LAST);
  assign w_next_ptr  = (r_gidx == PW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;

  // Handshake is combinational from the registered grant: zero latency to uart_tx.
  assign o_req_ready     = w_locked ? (r_grant & {NUM_REQ{i_uart_tx_ready}}) : '0;
  assign o_uart_tx_valid = w_xfer;
  assign o_uart_tx_data  = w_locked ? i_req_data[r_gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign o_grant         = r_grant;
  assign o_busy          = (r_state != IDLE);
  assign o_timeout_evt   = r_timeout_evt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_gidx        <= '0;
      r_rr_ptr      <= '0;
      r_tmo_cnt     <= '0;
      r_timeout_evt <= 1'b0;
    end else begin
      r_timeout_evt <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tmo_cnt <= '0;
          if (w_any) begin
            r_grant <= w_pick;
            r_gidx  <= w_pick_idx;
            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_xfer) begin
            r_tmo_cnt <= '0;
            if (w_own_last) begin
              r_state  <= IDLE;
              r_grant  <= '0;
              r_gidx   <= '0;
              r_rr_ptr <= w_next_ptr;
            end else begin
              r_state <= SETTLE;
            end
          end else if (w_tmo_hit) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_gidx        <= '0;
            r_rr_ptr      <= w_next_ptr;
            r_tmo_cnt     <= '0;
            r_timeout_evt <= 1'b1;
          end else if (!w_own_valid && (r_tmo_cnt != '1)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        // uart_tx_ready is still high in the cycle after an accept; hold off one cycle.
        SETTLE: begin
          r_tmo_cnt <= '0;
          r_state   <= LOCKED;
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_grant_onehot0: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(r_grant));
  a_valid_ready:   assert property (@(posedge i_clk) disable iff (i_rst) o_uart_tx_valid |-> i_uart_tx_ready);
  a_ready_onehot0: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(o_req_ready));
  a_busy_grant:    assert property (@(posedge i_clk) disable iff (i_rst) o_busy == (|r_grant));
`endif

endmodule
